// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host sequencer: opcodes, instruction field layout,
// sequencer state encoding and the instruction builder.
package tpu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int INSTR_WIDTH = 16;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD_A = 4'd1;
  localparam logic [3:0] OP_LOAD_B = 4'd2;
  localparam logic [3:0] OP_RUN    = 4'd3;
  localparam logic [3:0] OP_READ   = 4'd4;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int ROW_MSB  = 11;
  localparam int ROW_LSB  = 10;
  localparam int COL_MSB  = 9;
  localparam int COL_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_LOAD_B   = 3'd2,
    ST_RUN      = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RD_OUT   = 3'd6
  } seq_state_t;

  // Flat element index maps onto row = idx[3:2], col = idx[1:0].
  function automatic logic [INSTR_WIDTH-1:0] make_instr(
    input logic [3:0]            op,
    input logic [3:0]            idx,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [INSTR_WIDTH-1:0] word;
    word                    = '0;
    word[OPC_MSB:OPC_LSB]   = op;
    word[ROW_MSB:ROW_LSB]   = idx[3:2];
    word[COL_MSB:COL_LSB]   = idx[1:0];
    word[DATA_MSB:DATA_LSB] = data;
    return word;
  endfunction

endpackage

// File: rtl/tpu_seq_result_buf.sv
// Single-entry result holding register: captures one TPU result byte and presents it
// on a valid/ready stream until the downstream accepts it.
module tpu_seq_result_buf
  import tpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  fire
);

  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;

  assign data  = data_reg;
  assign valid = valid_reg;
  assign fire  = valid_reg & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
    end else if (fire) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side TPU driver: loads A/B operands, runs the core, then reads back 16 results.
// Optional macro TPU_SEQ_PERF_EN enables the per-job busy cycle counter on cycle_count.
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 10,
  parameter int RD_LAT         = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  input  logic [DATA_WIDTH-1:0]  result,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            cycle_count
);

  localparam int RUN_W  = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam int WAIT_W = $clog2(RD_LAT + 2);

  seq_state_t             state_reg;
  logic [3:0]             index_reg;
  logic [RUN_W-1:0]       run_cnt_reg;
  logic [WAIT_W-1:0]      wait_cnt_reg;
  logic [INSTR_WIDTH-1:0] instruction_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   in_ready_reg;
  logic                   last_index;
  logic                   capture;
  logic                   out_fire;

  assign last_index  = (index_reg == 4'd15);
  assign capture     = (state_reg == ST_RD_WAIT) && (wait_cnt_reg == WAIT_W'(RD_LAT));
  assign instruction = instruction_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign in_ready    = in_ready_reg;

  tpu_seq_result_buf u_result_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (result),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .fire      (out_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      index_reg       <= 4'd0;
      run_cnt_reg     <= '0;
      wait_cnt_reg    <= '0;
      instruction_reg <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      in_ready_reg    <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      instruction_reg <= make_instr(OP_NOP, 4'd0, '0);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_LOAD_A;
            index_reg    <= 4'd0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (in_valid && in_ready_reg) begin
            instruction_reg <= make_instr(OP_LOAD_A, index_reg, in_data);
            index_reg       <= last_index ? 4'd0 : index_reg + 4'd1;
            if (last_index) state_reg <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (in_valid && in_ready_reg) begin
            instruction_reg <= make_instr(OP_LOAD_B, index_reg, in_data);
            index_reg       <= last_index ? 4'd0 : index_reg + 4'd1;
            if (last_index) begin
              state_reg    <= ST_RUN;
              in_ready_reg <= 1'b0;
              run_cnt_reg  <= '0;
            end
          end
        end
        ST_RUN: begin
          // Each RUN-state edge issues RUN, so the word is held for exactly COMPUTE_CYCLES.
          instruction_reg <= make_instr(OP_RUN, 4'd0, '0);
          if (run_cnt_reg == RUN_W'(COMPUTE_CYCLES - 1)) begin
            state_reg   <= ST_RD_ISSUE;
            index_reg   <= 4'd0;
            run_cnt_reg <= '0;
          end else begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          instruction_reg <= make_instr(OP_READ, index_reg, '0);
          state_reg       <= ST_RD_WAIT;
          wait_cnt_reg    <= '0;
        end
        ST_RD_WAIT: begin
          if (capture) begin
            state_reg <= ST_RD_OUT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_RD_OUT: begin
          if (out_fire) begin
            if (last_index) begin
              state_reg    <= ST_IDLE;
              index_reg    <= 4'd0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              index_reg <= index_reg + 4'd1;
              state_reg <= ST_RD_ISSUE;
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] cycle_count_reg;

  // Cleared on start accept; busy drops on the done edge so the value freezes there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_reg <= 16'd0;
    end else if (state_reg == ST_IDLE && start) begin
      cycle_count_reg <= 16'd0;
    end else if (busy_reg && cycle_count_reg != 16'hFFFF) begin
      cycle_count_reg <= cycle_count_reg + 16'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`else
  assign cycle_count = 16'd0;
`endif

endmodule
